// File: rtl/wb_regfile_if.sv
// Writeback/read-port bundle for wb_regfile: MEM/WB inputs, decode read ports,
// forwarded writeback value and retire counter.
interface wb_regfile_if;
  logic [63:0] wb_read_data;
  logic [63:0] wb_alu_result;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        wb_mem_to_reg;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic [63:0] wb_data;
  logic [63:0] retire_count;

  modport master (
    output wb_read_data, wb_alu_result, wb_rd, wb_reg_write, wb_mem_to_reg,
    output rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, wb_data, retire_count
  );

  modport slave (
    input  wb_read_data, wb_alu_result, wb_rd, wb_reg_write, wb_mem_to_reg,
    input  rs1_addr, rs2_addr,
    output rs1_data, rs2_data, wb_data, retire_count
  );
endinterface

// File: rtl/wb_regfile.sv
// 31x64 integer register file (x0 hardwired to zero) with writeback mux,
// optional same-cycle write-to-read bypass and an effective-write counter.
module wb_regfile #(
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  wb_regfile_if.slave  bus
);
  localparam int unsigned XLEN = 64;
  localparam int unsigned NREG = 32;

  logic [XLEN-1:0] regs [1:NREG-1];
  logic [XLEN-1:0] count_q;
  logic [XLEN-1:0] wb_sel;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            we;

  assign wb_sel = bus.wb_mem_to_reg ? bus.wb_read_data : bus.wb_alu_result;
  // Reset wins over a concurrent writeback; x0 writes are dropped.
  assign we     = !rst && bus.wb_reg_write && (bus.wb_rd != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 1; i < NREG; i++) begin
        regs[i] <= '0;
      end
      count_q <= '0;
    end else if (we) begin
      regs[bus.wb_rd] <= wb_sel;
      count_q         <= count_q + XLEN'(1);
    end
  end

  always_comb begin
    rs1_val = '0;
    if (bus.rs1_addr != 5'd0) begin
      if (BYPASS_EN && we && (bus.rs1_addr == bus.wb_rd)) rs1_val = wb_sel;
      else                                               rs1_val = regs[bus.rs1_addr];
    end
  end

  always_comb begin
    rs2_val = '0;
    if (bus.rs2_addr != 5'd0) begin
      if (BYPASS_EN && we && (bus.rs2_addr == bus.wb_rd)) rs2_val = wb_sel;
      else                                               rs2_val = regs[bus.rs2_addr];
    end
  end

  assign bus.wb_data      = wb_sel;
  assign bus.rs1_data     = rs1_val;
  assign bus.rs2_data     = rs2_val;
  assign bus.retire_count = count_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: bypass and non-bypass instances share
// stimulus; hand vectors, corner sequences and a random run against a model.
module tb_wb_regfile;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_regfile_if bus_b ();
  wb_regfile_if bus_n ();

  assign bus_n.wb_read_data  = bus_b.wb_read_data;
  assign bus_n.wb_alu_result = bus_b.wb_alu_result;
  assign bus_n.wb_rd         = bus_b.wb_rd;
  assign bus_n.wb_reg_write  = bus_b.wb_reg_write;
  assign bus_n.wb_mem_to_reg = bus_b.wb_mem_to_reg;
  assign bus_n.rs1_addr      = bus_b.rs1_addr;
  assign bus_n.rs2_addr      = bus_b.rs2_addr;

  wb_regfile #(.BYPASS_EN(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  wb_regfile #(.BYPASS_EN(1'b0)) dut_n (.clk(clk), .rst(rst), .bus(bus_n));

  typedef struct {
    logic [63:0] b1, b2, n1, n2, wbd, cnt;
  } exp_t;

  typedef struct {
    logic        rst, we, m2r;
    logic [4:0]  rd, rs1, rs2;
    logic [63:0] alu, rdata;
    logic [63:0] eb1, eb2, en1, en2, ewbd, ecnt;
  } vec_t;

  exp_t        sb[$];
  logic [63:0] mregs [32];
  logic [63:0] mcnt;
  int          passed = 0;
  int          total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  function automatic logic [63:0] model_wbd(input logic m2r, input logic [63:0] alu,
                                            input logic [63:0] rdata);
    return m2r ? rdata : alu;
  endfunction

  // Drive one cycle's inputs at the falling edge and queue the model's expectation.
  task automatic apply(input logic r, input logic we, input logic m2r, input logic [4:0] rd,
                       input logic [4:0] a1, input logic [4:0] a2,
                       input logic [63:0] alu, input logic [63:0] rdata);
    exp_t        e;
    logic [63:0] w;
    logic        eff;
    @(negedge clk);
    rst = r;
    bus_b.wb_reg_write  = we;
    bus_b.wb_mem_to_reg = m2r;
    bus_b.wb_rd         = rd;
    bus_b.rs1_addr      = a1;
    bus_b.rs2_addr      = a2;
    bus_b.wb_alu_result = alu;
    bus_b.wb_read_data  = rdata;
    w   = model_wbd(m2r, alu, rdata);
    eff = !r && we && (rd != 5'd0);
    e.wbd = w;
    e.cnt = mcnt;
    e.n1  = (a1 == 5'd0) ? 64'd0 : mregs[a1];
    e.n2  = (a2 == 5'd0) ? 64'd0 : mregs[a2];
    e.b1  = (a1 != 5'd0 && eff && a1 == rd) ? w : e.n1;
    e.b2  = (a2 != 5'd0 && eff && a2 == rd) ? w : e.n2;
    sb.push_back(e);
  endtask

  task automatic sample(input string tag);
    exp_t e;
    #2;
    if (sb.size() == 0) begin
      total++;
      $display("FAIL %s_sb: got empty scoreboard required one entry", tag);
      return;
    end
    e = sb.pop_front();
    check({tag, "_rs1_byp"}, bus_b.rs1_data, e.b1);
    check({tag, "_rs2_byp"}, bus_b.rs2_data, e.b2);
    check({tag, "_rs1_nob"}, bus_n.rs1_data, e.n1);
    check({tag, "_rs2_nob"}, bus_n.rs2_data, e.n2);
    check({tag, "_wbd"},     bus_b.wb_data,  e.wbd);
    check({tag, "_cnt_byp"}, bus_b.retire_count, e.cnt);
    check({tag, "_cnt_nob"}, bus_n.retire_count, e.cnt);
  endtask

  // Advance the model at the rising edge using the currently applied inputs.
  task automatic commit();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
      mcnt = 64'd0;
    end else if (bus_b.wb_reg_write && bus_b.wb_rd != 5'd0) begin
      mregs[bus_b.wb_rd] = model_wbd(bus_b.wb_mem_to_reg, bus_b.wb_alu_result,
                                     bus_b.wb_read_data);
      mcnt = mcnt + 64'd1;
    end
  endtask

  function automatic vec_t mk(input logic r, input logic we, input logic m2r,
                              input logic [4:0] rd, input logic [4:0] a1, input logic [4:0] a2,
                              input logic [63:0] alu, input logic [63:0] rdata,
                              input logic [63:0] eb1, input logic [63:0] eb2,
                              input logic [63:0] en1, input logic [63:0] en2,
                              input logic [63:0] ewbd, input logic [63:0] ecnt);
    vec_t v;
    v.rst = r; v.we = we; v.m2r = m2r; v.rd = rd; v.rs1 = a1; v.rs2 = a2;
    v.alu = alu; v.rdata = rdata;
    v.eb1 = eb1; v.eb2 = eb2; v.en1 = en1; v.en2 = en2; v.ewbd = ewbd; v.ecnt = ecnt;
    return v;
  endfunction

  vec_t vt [10];

  initial begin
    string tag;
    logic  r, we, m2r;
    logic [4:0] rd, a1, a2;

    for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
    mcnt = 64'd0;
    rst = 1'b1;
    bus_b.wb_reg_write = 1'b0; bus_b.wb_mem_to_reg = 1'b0; bus_b.wb_rd = 5'd0;
    bus_b.rs1_addr = 5'd0; bus_b.rs2_addr = 5'd0;
    bus_b.wb_alu_result = 64'd0; bus_b.wb_read_data = 64'd0;

    // First reset edge: contents before it are undefined and not checked.
    commit();
    apply(1'b1, 1'b1, 1'b0, 5'd4, 5'd4, 5'd0, 64'h55, 64'd0);
    sample("reset");
    commit();

    vt[0] = mk(0,1,0,5'd5,5'd5,5'd0,64'h1234,64'd0, 64'h1234,0,0,0,64'h1234,0);
    vt[1] = mk(0,0,0,5'd0,5'd5,5'd5,64'd0,64'd0, 64'h1234,64'h1234,64'h1234,64'h1234,0,1);
    vt[2] = mk(0,1,1,5'd7,5'd7,5'd7,64'd0,64'hDEAD_BEEF,
               64'hDEAD_BEEF,64'hDEAD_BEEF,0,0,64'hDEAD_BEEF,1);
    vt[3] = mk(0,0,0,5'd0,5'd7,5'd7,64'd0,64'd0, 64'hDEAD_BEEF,64'hDEAD_BEEF,
               64'hDEAD_BEEF,64'hDEAD_BEEF,0,2);
    vt[4] = mk(0,1,0,5'd0,5'd0,5'd0,64'hFFFF,64'd0, 0,0,0,0,64'hFFFF,2);
    vt[5] = mk(0,0,0,5'd0,5'd0,5'd5,64'd0,64'd0, 0,64'h1234,0,64'h1234,0,2);
    vt[6] = mk(0,0,1,5'd3,5'd3,5'd3,64'hBB,64'hAA, 0,0,0,0,64'hAA,2);
    vt[7] = mk(0,1,0,5'd9,5'd9,5'd7,64'd1,64'd0, 1,64'hDEAD_BEEF,0,64'hDEAD_BEEF,1,2);
    vt[8] = mk(0,1,0,5'd9,5'd9,5'd9,64'd2,64'd0, 2,2,1,1,2,3);
    vt[9] = mk(0,0,0,5'd9,5'd9,5'd0,64'd0,64'd0, 2,0,2,0,0,4);

    foreach (vt[i]) begin
      tag = $sformatf("vec%0d", i);
      apply(vt[i].rst, vt[i].we, vt[i].m2r, vt[i].rd, vt[i].rs1, vt[i].rs2,
            vt[i].alu, vt[i].rdata);
      sample({tag, "_m"});
      check({tag, "_rs1_byp"}, bus_b.rs1_data, vt[i].eb1);
      check({tag, "_rs2_byp"}, bus_b.rs2_data, vt[i].eb2);
      check({tag, "_rs1_nob"}, bus_n.rs1_data, vt[i].en1);
      check({tag, "_rs2_nob"}, bus_n.rs2_data, vt[i].en2);
      check({tag, "_wbd"},     bus_b.wb_data,  vt[i].ewbd);
      check({tag, "_cnt"},     bus_b.retire_count, vt[i].ecnt);
      commit();
    end

    // Counter wrap after a deposited all-ones value.
    @(negedge clk);
    dut_b.count_q = 64'hFFFF_FFFF_FFFF_FFFF;
    dut_n.count_q = 64'hFFFF_FFFF_FFFF_FFFF;
    mcnt = 64'hFFFF_FFFF_FFFF_FFFF;
    apply(0, 1, 0, 5'd12, 5'd0, 5'd0, 64'h77, 64'd0);
    sample("wrap_pre");
    commit();
    apply(0, 0, 0, 5'd0, 5'd12, 5'd0, 64'd0, 64'd0);
    sample("wrap_post");
    check("wrap_cnt_zero", bus_b.retire_count, 64'd0);
    commit();

    // Fill x1..x31 with their index, then reset concurrent with a write to x3.
    for (int i = 1; i < 32; i++) begin
      apply(0, 1, 0, 5'(i), 5'(i), 5'(i - 1), 64'(i), 64'd0);
      sample($sformatf("fill%0d", i));
      commit();
    end
    apply(1, 1, 0, 5'd3, 5'd3, 5'd31, 64'h99, 64'd0);
    sample("rstpulse");
    check("rstpulse_no_bypass", bus_b.rs1_data, 64'd3);
    commit();
    for (int i = 0; i < 32; i += 2) begin
      apply(0, 0, 0, 5'd0, 5'(i), 5'(i + 1), 64'd0, 64'd0);
      sample($sformatf("postrst%0d", i));
      check($sformatf("postrst%0d_rs1", i), bus_b.rs1_data, 64'd0);
      check($sformatf("postrst%0d_rs2", i), bus_b.rs2_data, 64'd0);
      check($sformatf("postrst%0d_cnt", i), bus_b.retire_count, 64'd0);
      commit();
    end

    // Random write/read traffic including x0, bypass collisions and resets.
    for (int c = 0; c < 1000; c++) begin
      r   = ($urandom_range(0, 99) < 3);
      we  = ($urandom_range(0, 99) < 70);
      m2r = 1'($urandom_range(0, 1));
      rd  = 5'($urandom_range(0, 31));
      a1  = ($urandom_range(0, 1) == 0) ? rd : 5'($urandom_range(0, 31));
      a2  = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
      apply(r, we, m2r, rd, a1, a2, {$urandom, $urandom}, {$urandom, $urandom});
      sample($sformatf("rnd%0d", c));
      commit();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
